// File: rtl/c7bbiu_arb_if.sv
// c7bbiu_arb_if: core-side and memory-side handshake bundle for c7bbiu_arb.
// slave  = arbiter view, master = environment (core + memory) view.
interface c7bbiu_arb_if #(
  parameter int NCH = 2,
  parameter int AW  = 32,
  parameter int DW  = 64
);
  // core read channels
  logic [NCH-1:0]    rd_req;
  logic [NCH*AW-1:0] rd_addr;
  logic [NCH-1:0]    rd_cancel;
  logic [NCH-1:0]    rd_ack;
  logic [NCH-1:0]    rd_data_valid;
  logic [DW-1:0]     rd_data;
  // core write channel
  logic              wr_req;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic [DW/8-1:0]   wr_strb;
  logic              wr_ack;
  logic              wr_done;
  // memory read port
  logic              mem_rd_req;
  logic [AW-1:0]     mem_rd_addr;
  logic              mem_rd_ack;
  logic              mem_data_valid;
  logic [DW-1:0]     mem_data;
  // memory write port
  logic              mem_wr_req;
  logic [AW-1:0]     mem_wr_addr;
  logic [DW-1:0]     mem_wr_data;
  logic [DW/8-1:0]   mem_wr_strb;
  logic              mem_wr_ack;
  logic              mem_write_done;

  modport slave (
    input  rd_req, rd_addr, rd_cancel,
    input  wr_req, wr_addr, wr_data, wr_strb,
    input  mem_rd_ack, mem_data_valid, mem_data,
    input  mem_wr_ack, mem_write_done,
    output rd_ack, rd_data_valid, rd_data,
    output wr_ack, wr_done,
    output mem_rd_req, mem_rd_addr,
    output mem_wr_req, mem_wr_addr, mem_wr_data, mem_wr_strb
  );

  modport master (
    output rd_req, rd_addr, rd_cancel,
    output wr_req, wr_addr, wr_data, wr_strb,
    output mem_rd_ack, mem_data_valid, mem_data,
    output mem_wr_ack, mem_write_done,
    input  rd_ack, rd_data_valid, rd_data,
    input  wr_ack, wr_done,
    input  mem_rd_req, mem_rd_addr,
    input  mem_wr_req, mem_wr_addr, mem_wr_data, mem_wr_strb
  );
endinterface

// File: rtl/c7bbiu_arb.sv
// c7bbiu_arb: merges NCH read channels and one write channel onto a single
// external memory read port and write port. One outstanding read and one
// outstanding write; reads that hit a pending write's 8-byte word are held
// back until that write completes. Per-channel cancel drops the return beat.
// Optional macro C7B_BIU_ARB_RR_EN selects round-robin arbitration; without
// it the lowest-index eligible channel wins.
module c7bbiu_arb #(
  parameter int NCH = 2,
  parameter int AW  = 32,
  parameter int DW  = 64
) (
  input logic         clk,
  input logic         resetn,
  c7bbiu_arb_if.slave bus
);
  localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {R_IDLE, R_REQ, R_DATA} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_DONE} wr_state_t;

  rd_state_t       r_rd_st, w_rd_nx;
  wr_state_t       r_wr_st, w_wr_nx;
  logic [GW-1:0]   r_gnt;
  logic [GW-1:0]   w_gnt;
  logic            w_gnt_vld;
  logic            r_cancelled;
  logic            w_cancel_now;
  logic [AW-1:0]   r_rd_addr;
  logic [AW-1:0]   r_wr_addr;
  logic [DW-1:0]   r_wr_data;
  logic [DW/8-1:0] r_wr_strb;
  logic            w_wr_pend;
  logic [NCH-1:0]  w_elig;

  assign bus.rd_data     = bus.mem_data;
  assign bus.mem_rd_addr = r_rd_addr;
  assign bus.mem_wr_addr = r_wr_addr;
  assign bus.mem_wr_data = r_wr_data;
  assign bus.mem_wr_strb = r_wr_strb;

  // A write held by the arbiter (issued or awaiting completion) blocks reads of the same 8-byte word.
  always_comb begin
    w_wr_pend = (r_wr_st != W_IDLE);
    w_elig    = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      w_elig[i] = bus.rd_req[i] &&
                  !(w_wr_pend && (bus.rd_addr[i*AW+3 +: AW-3] == r_wr_addr[AW-1:3]));
    end
  end

`ifdef C7B_BIU_ARB_RR_EN
  logic [GW-1:0] r_ptr;

  // Round-robin pick: first eligible channel after the last grant.
  always_comb begin
    w_gnt     = '0;
    w_gnt_vld = 1'b0;
    for (int unsigned k = 1; k <= NCH; k++) begin
      if (!w_gnt_vld && w_elig[(int unsigned'(r_ptr) + k) % NCH]) begin
        w_gnt     = GW'((int unsigned'(r_ptr) + k) % NCH);
        w_gnt_vld = 1'b1;
      end
    end
  end

  // Pointer remembers the most recent grant.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      r_ptr <= GW'(NCH - 1);
    else if (r_rd_st == R_IDLE && w_gnt_vld)
      r_ptr <= w_gnt;
  end
`else
  // Fixed priority pick: lowest eligible index wins.
  always_comb begin
    w_gnt     = '0;
    w_gnt_vld = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (!w_gnt_vld && w_elig[i]) begin
        w_gnt     = GW'(i);
        w_gnt_vld = 1'b1;
      end
    end
  end
`endif

  // Read FSM next state and combinational handshake outputs.
  always_comb begin
    w_rd_nx            = r_rd_st;
    bus.mem_rd_req     = 1'b0;
    bus.rd_ack         = '0;
    bus.rd_data_valid  = '0;
    w_cancel_now       = bus.rd_cancel[r_gnt];
    case (r_rd_st)
      R_IDLE: if (w_gnt_vld) w_rd_nx = R_REQ;
      R_REQ: begin
        bus.mem_rd_req = 1'b1;
        if (bus.mem_rd_ack) begin
          bus.rd_ack[r_gnt] = 1'b1;
          w_rd_nx           = R_DATA;
        end
      end
      R_DATA: begin
        if (bus.mem_data_valid) begin
          // a cancel arriving with the beat still suppresses it
          bus.rd_data_valid[r_gnt] = !(r_cancelled || w_cancel_now);
          w_rd_nx                  = R_IDLE;
        end
      end
      default: w_rd_nx = R_IDLE;
    endcase
  end

  // Read FSM state, grant, address and cancel tracking.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rd_st     <= R_IDLE;
      r_gnt       <= '0;
      r_rd_addr   <= '0;
      r_cancelled <= 1'b0;
    end else begin
      r_rd_st <= w_rd_nx;
      if (r_rd_st == R_IDLE) begin
        r_cancelled <= 1'b0;
        if (w_gnt_vld) begin
          r_gnt     <= w_gnt;
          r_rd_addr <= bus.rd_addr[w_gnt*AW +: AW];
        end
      end else if (w_cancel_now) begin
        r_cancelled <= 1'b1;
      end
    end
  end

  // Write FSM next state and combinational handshake outputs.
  always_comb begin
    w_wr_nx        = r_wr_st;
    bus.mem_wr_req = 1'b0;
    bus.wr_ack     = 1'b0;
    bus.wr_done    = 1'b0;
    case (r_wr_st)
      W_IDLE: if (bus.wr_req) w_wr_nx = W_REQ;
      W_REQ: begin
        bus.mem_wr_req = 1'b1;
        if (bus.mem_wr_ack) begin
          bus.wr_ack = 1'b1;
          w_wr_nx    = W_DONE;
        end
      end
      W_DONE: begin
        if (bus.mem_write_done) begin
          bus.wr_done = 1'b1;
          w_wr_nx     = W_IDLE;
        end
      end
      default: w_wr_nx = W_IDLE;
    endcase
  end

  // Write FSM state and captured write payload.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_st   <= W_IDLE;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_wr_strb <= '0;
    end else begin
      r_wr_st <= w_wr_nx;
      if (r_wr_st == W_IDLE && bus.wr_req) begin
        r_wr_addr <= bus.wr_addr;
        r_wr_data <= bus.wr_data;
        r_wr_strb <= bus.wr_strb;
      end
    end
  end
endmodule

// File: tb/tb_c7bbiu_arb.sv
// tb_c7bbiu_arb: directed and randomized checks of c7bbiu_arb against a
// transaction-level reference (grant rule, address/data expectations).
module tb_c7bbiu_arb;
  localparam int NCH = 2;
  localparam int AW  = 32;
  localparam int DW  = 64;
`ifdef C7B_BIU_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  c7bbiu_arb_if #(.NCH(NCH), .AW(AW), .DW(DW)) bus ();
  c7bbiu_arb #(.NCH(NCH), .AW(AW), .DW(DW)) dut (.clk(clk), .resetn(resetn), .bus(bus.slave));

  int n_pass  = 0;
  int n_total = 0;
  logic [AW-1:0] a [NCH];

  // Reference grant rule: lowest requester, or first requester after the last grant.
  function automatic int pick(input logic [NCH-1:0] req, input int last);
    int c;
    for (int s = 0; s < NCH; s++) begin
      c = RR ? (last + 1 + s) % NCH : s;
      if (req[c]) return c;
    end
    return -1;
  endfunction

  task automatic idle_all();
    bus.rd_req = '0; bus.rd_addr = '0; bus.rd_cancel = '0;
    bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_strb = '0;
    bus.mem_rd_ack = 1'b0; bus.mem_data_valid = 1'b0; bus.mem_data = '0;
    bus.mem_wr_ack = 1'b0; bus.mem_write_done = 1'b0;
  endtask

  task automatic pack_addr();
    for (int i = 0; i < NCH; i++) bus.rd_addr[i*AW +: AW] = a[i];
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    idle_all();
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  // Plays the memory side of one read; returns what the core side observed.
  task automatic serve_read(input int ack_dly, input int dat_dly, input logic [DW-1:0] data,
                            input logic [NCH-1:0] cmask, input int cmode, input bit drop,
                            output logic [NCH-1:0] ack_s, output logic [NCH-1:0] dv_s,
                            output logic [DW-1:0] data_s, output logic [AW-1:0] addr_s,
                            output bit to);
    int n;
    to = 1'b0; n = 0; ack_s = '0; dv_s = '0; data_s = '0; addr_s = '0;
    while (bus.mem_rd_req !== 1'b1 && n < 30) begin @(posedge clk); #1; n++; end
    if (bus.mem_rd_req !== 1'b1) begin to = 1'b1; return; end
    addr_s = bus.mem_rd_addr;
    repeat (ack_dly) begin @(posedge clk); #1; end
    bus.mem_rd_ack = 1'b1;
    @(negedge clk); ack_s = bus.rd_ack;
    @(posedge clk); #1 bus.mem_rd_ack = 1'b0;
    if (drop) bus.rd_req = bus.rd_req & ~ack_s;
    for (int d = 0; d < dat_dly; d++) begin
      if (cmode == 1 && d == dat_dly - 1) bus.rd_cancel = cmask;
      @(posedge clk); #1 bus.rd_cancel = '0;
    end
    bus.mem_data_valid = 1'b1; bus.mem_data = data;
    if (cmode == 2) bus.rd_cancel = cmask;
    @(negedge clk); dv_s = bus.rd_data_valid; data_s = bus.rd_data;
    @(posedge clk); #1 bus.mem_data_valid = 1'b0; bus.rd_cancel = '0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; idle_all();
    #2;
    n_total++; if (bus.rd_ack !== '0) $display("FAIL rst_rd_ack: got %b want 0", bus.rd_ack); else n_pass++;
    n_total++; if (bus.rd_data_valid !== '0) $display("FAIL rst_rd_dv: got %b want 0", bus.rd_data_valid); else n_pass++;
    n_total++; if ({bus.mem_rd_req, bus.mem_wr_req, bus.wr_ack, bus.wr_done} !== 4'b0)
      $display("FAIL rst_strobes: got %b want 0000", {bus.mem_rd_req, bus.mem_wr_req, bus.wr_ack, bus.wr_done}); else n_pass++;
    n_total++; if (bus.mem_rd_addr !== '0) $display("FAIL rst_mem_rd_addr: got %h want 0", bus.mem_rd_addr); else n_pass++;
    n_total++; if ({bus.mem_wr_addr, bus.mem_wr_data, bus.mem_wr_strb} !== '0)
      $display("FAIL rst_mem_wr_bus: got %h/%h/%h want 0", bus.mem_wr_addr, bus.mem_wr_data, bus.mem_wr_strb); else n_pass++;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  task automatic test_single_read();
    logic [NCH-1:0] e_ack, e_dv;
    logic e_req;
    do_reset();
    a[0] = 32'h1c000000; a[1] = 32'h0; pack_addr();
    bus.rd_req = 2'b01;
    for (int c = 0; c < 7; c++) begin
      bus.mem_rd_ack     = (c == 3);
      bus.mem_data_valid = (c == 5);
      bus.mem_data       = (c == 5) ? 64'hDEADBEEF_00000001 : 64'h0;
      if (c == 4) bus.rd_req = '0;
      @(negedge clk);
      e_req = (c >= 1 && c <= 3);
      e_ack = (c == 3) ? 2'b01 : 2'b00;
      e_dv  = (c == 5) ? 2'b01 : 2'b00;
      n_total++; if (bus.mem_rd_req !== e_req) $display("FAIL single_mem_rd_req c%0d: got %b want %b", c, bus.mem_rd_req, e_req); else n_pass++;
      n_total++; if (bus.rd_ack !== e_ack) $display("FAIL single_rd_ack c%0d: got %b want %b", c, bus.rd_ack, e_ack); else n_pass++;
      n_total++; if (bus.rd_data_valid !== e_dv) $display("FAIL single_rd_dv c%0d: got %b want %b", c, bus.rd_data_valid, e_dv); else n_pass++;
      if (c == 1) begin
        n_total++; if (bus.mem_rd_addr !== 32'h1c000000) $display("FAIL single_addr: got %h want 1c000000", bus.mem_rd_addr); else n_pass++;
      end
      if (c == 5) begin
        n_total++; if (bus.rd_data !== 64'hDEADBEEF_00000001) $display("FAIL single_data: got %h want deadbeef00000001", bus.rd_data); else n_pass++;
      end
      @(posedge clk); #1;
    end
    idle_all();
  endtask

  task automatic test_contention();
    logic [NCH-1:0] ack_s, dv_s, e;
    logic [DW-1:0] ds;
    logic [AW-1:0] as_;
    bit to;
    int g, last;
    do_reset();
    a[0] = 32'h1c000000; a[1] = 32'h1c001000; pack_addr();
    bus.rd_req = 2'b11;
    last = NCH - 1;
    for (int t = 0; t < 4; t++) begin
      g = pick(2'b11, last); last = g;
      e = '0; e[g] = 1'b1;
      serve_read(t % 2, 1, {$urandom, $urandom}, '0, 0, 1'b0, ack_s, dv_s, ds, as_, to);
      n_total++; if (to) $display("FAIL cont_timeout t%0d: got no mem_rd_req want mem_rd_req", t); else n_pass++;
      n_total++; if (ack_s !== e) $display("FAIL cont_grant t%0d: got %b want %b", t, ack_s, e); else n_pass++;
      n_total++; if (as_ !== a[g]) $display("FAIL cont_addr t%0d: got %h want %h", t, as_, a[g]); else n_pass++;
    end
    bus.rd_req = '0;
  endtask

  task automatic test_cancel();
    logic [NCH-1:0] ack_s, dv_s;
    logic [DW-1:0] ds, d;
    logic [AW-1:0] as_;
    bit to;
    do_reset();
    a[0] = 32'h1c000040; a[1] = 32'h1c000080; pack_addr();
    bus.rd_req = 2'b01;
    serve_read(1, 2, 64'h1111, 2'b01, 1, 1'b1, ack_s, dv_s, ds, as_, to);
    n_total++; if (ack_s !== 2'b01 || to) $display("FAIL cancel_ack: got %b want 01", ack_s); else n_pass++;
    n_total++; if (dv_s !== 2'b00) $display("FAIL cancel_dv: got %b want 00", dv_s); else n_pass++;
    bus.rd_req = 2'b10;
    @(negedge clk);
    n_total++; if (bus.mem_rd_req !== 1'b0) $display("FAIL cancel_idle: got %b want 0", bus.mem_rd_req); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (bus.mem_rd_req !== 1'b1) $display("FAIL cancel_next_req: got %b want 1", bus.mem_rd_req); else n_pass++;
    d = {$urandom, $urandom};
    serve_read(0, 1, d, 2'b01, 2, 1'b1, ack_s, dv_s, ds, as_, to);
    n_total++; if (dv_s !== 2'b10 || to) $display("FAIL cancel_other_dv: got %b want 10", dv_s); else n_pass++;
    n_total++; if (ds !== d) $display("FAIL cancel_other_data: got %h want %h", ds, d); else n_pass++;
    bus.rd_req = 2'b01;
    serve_read(0, 0, 64'h2222, 2'b01, 2, 1'b1, ack_s, dv_s, ds, as_, to);
    n_total++; if (dv_s !== 2'b00 || to) $display("FAIL cancel_same_cycle_dv: got %b want 00", dv_s); else n_pass++;
    bus.rd_req = 2'b01;
    serve_read(2, 1, 64'h3333, '0, 0, 1'b1, ack_s, dv_s, ds, as_, to);
    n_total++; if (dv_s !== 2'b01 || to) $display("FAIL cancel_cleared_dv: got %b want 01", dv_s); else n_pass++;
  endtask

  task automatic test_raw();
    logic [NCH-1:0] ack_s, dv_s;
    logic [DW-1:0] ds, wd, d;
    logic [AW-1:0] as_;
    bit to;
    int bad;
    do_reset();
    wd = {$urandom, $urandom};
    bus.wr_req = 1'b1; bus.wr_addr = 32'h1c000100; bus.wr_data = wd; bus.wr_strb = 8'h0F;
    @(posedge clk); #1;
    n_total++; if (bus.mem_wr_req !== 1'b1) $display("FAIL raw_mem_wr_req: got %b want 1", bus.mem_wr_req); else n_pass++;
    n_total++; if ({bus.mem_wr_addr, bus.mem_wr_data, bus.mem_wr_strb} !== {32'h1c000100, wd, 8'h0F})
      $display("FAIL raw_wr_payload: got %h/%h/%h want 1c000100/%h/0f", bus.mem_wr_addr, bus.mem_wr_data, bus.mem_wr_strb, wd); else n_pass++;
    bus.mem_wr_ack = 1'b1;
    @(negedge clk);
    n_total++; if (bus.wr_ack !== 1'b1) $display("FAIL raw_wr_ack: got %b want 1", bus.wr_ack); else n_pass++;
    @(posedge clk); #1 bus.mem_wr_ack = 1'b0; bus.wr_req = 1'b0;
    a[1] = 32'h1c000104; a[0] = 32'h1c000200; pack_addr();
    bus.rd_req = 2'b10;
    bad = 0;
    for (int c = 0; c < 4; c++) begin @(negedge clk); if (bus.mem_rd_req) bad++; @(posedge clk); #1; end
    n_total++; if (bad != 0) $display("FAIL raw_blocked: got %0d req cycles want 0", bad); else n_pass++;
    bus.rd_req = 2'b11;
    d = {$urandom, $urandom};
    serve_read(0, 1, d, '0, 0, 1'b1, ack_s, dv_s, ds, as_, to);
    n_total++; if (ack_s !== 2'b01 || to) $display("FAIL raw_bypass_ack: got %b want 01", ack_s); else n_pass++;
    n_total++; if (as_ !== 32'h1c000200) $display("FAIL raw_bypass_addr: got %h want 1c000200", as_); else n_pass++;
    n_total++; if (dv_s !== 2'b01 || ds !== d) $display("FAIL raw_bypass_dv: got %b/%h want 01/%h", dv_s, ds, d); else n_pass++;
    bad = 0;
    for (int c = 0; c < 2; c++) begin @(negedge clk); if (bus.mem_rd_req) bad++; @(posedge clk); #1; end
    bus.mem_write_done = 1'b1;
    @(negedge clk); if (bus.mem_rd_req) bad++;
    n_total++; if (bus.wr_done !== 1'b1) $display("FAIL raw_wr_done: got %b want 1", bus.wr_done); else n_pass++;
    @(posedge clk); #1 bus.mem_write_done = 1'b0;
    @(negedge clk); if (bus.mem_rd_req) bad++;
    n_total++; if (bad != 0) $display("FAIL raw_still_blocked: got %0d req cycles want 0", bad); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (bus.mem_rd_req !== 1'b1 || bus.mem_rd_addr !== 32'h1c000104)
      $display("FAIL raw_release: got %b/%h want 1/1c000104", bus.mem_rd_req, bus.mem_rd_addr); else n_pass++;
    d = {$urandom, $urandom};
    serve_read(0, 0, d, '0, 0, 1'b1, ack_s, dv_s, ds, as_, to);
    n_total++; if (ack_s !== 2'b10 || dv_s !== 2'b10 || ds !== d || to)
      $display("FAIL raw_ch1_read: got %b/%b/%h want 10/10/%h", ack_s, dv_s, ds, d); else n_pass++;
  endtask

  task automatic test_concurrency();
    logic [DW-1:0] d;
    bit do_rd;
    do_reset();
    for (int r = 0; r < 2; r++) begin
      a[0] = 32'h1c000400; pack_addr();
      bus.rd_req = 2'b01; bus.wr_req = 1'b1; bus.wr_addr = 32'h1c000300; bus.wr_data = '1; bus.wr_strb = '1;
      @(posedge clk); #1;
      bus.mem_rd_ack = 1'b1; bus.mem_wr_ack = 1'b1;
      @(negedge clk);
      n_total++; if ({bus.mem_wr_req, bus.mem_rd_req} !== 2'b11) $display("FAIL conc_both_req r%0d: got %b want 11", r, {bus.mem_wr_req, bus.mem_rd_req}); else n_pass++;
      n_total++; if ({bus.wr_ack, bus.rd_ack} !== 3'b101) $display("FAIL conc_acks r%0d: got %b want 101", r, {bus.wr_ack, bus.rd_ack}); else n_pass++;
      @(posedge clk); #1;
      bus.mem_rd_ack = 1'b0; bus.mem_wr_ack = 1'b0; bus.rd_req = '0; bus.wr_req = 1'b0;
      for (int s = 0; s < 2; s++) begin
        do_rd = (s == 0) ^ (r == 1);
        d = {$urandom, $urandom};
        if (do_rd) begin bus.mem_data_valid = 1'b1; bus.mem_data = d; end
        else bus.mem_write_done = 1'b1;
        @(negedge clk);
        n_total++; if (bus.rd_data_valid !== (do_rd ? 2'b01 : 2'b00) || bus.wr_done !== !do_rd)
          $display("FAIL conc_done r%0d s%0d: got dv=%b wd=%b want rd_first=%b", r, s, bus.rd_data_valid, bus.wr_done, do_rd); else n_pass++;
        if (do_rd) begin
          n_total++; if (bus.rd_data !== d) $display("FAIL conc_data r%0d: got %h want %h", r, bus.rd_data, d); else n_pass++;
        end
        @(posedge clk); #1 bus.mem_data_valid = 1'b0; bus.mem_write_done = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [NCH-1:0] ack_s, dv_s;
    logic [DW-1:0] ds;
    logic [AW-1:0] as_;
    bit to;
    do_reset();
    a[0] = 32'h1c000600; pack_addr();
    bus.rd_req = 2'b01; bus.wr_req = 1'b1; bus.wr_addr = 32'h1c000500; bus.wr_data = '1; bus.wr_strb = '1;
    @(posedge clk); #1 bus.mem_rd_ack = 1'b1; bus.mem_wr_ack = 1'b1;
    @(posedge clk); #1 idle_all();
    bus.mem_data_valid = 1'b1; bus.mem_write_done = 1'b1; bus.mem_data = {$urandom, $urandom};
    #1 resetn = 1'b0;
    #1;
    n_total++; if (bus.rd_data_valid !== '0 || bus.wr_done !== 1'b0)
      $display("FAIL rstmid_done: got dv=%b wd=%b want 00/0", bus.rd_data_valid, bus.wr_done); else n_pass++;
    n_total++; if ({bus.mem_rd_req, bus.mem_wr_req, bus.wr_ack, bus.rd_ack} !== 5'b0)
      $display("FAIL rstmid_strobes: got %b want 00000", {bus.mem_rd_req, bus.mem_wr_req, bus.wr_ack, bus.rd_ack}); else n_pass++;
    n_total++; if ({bus.mem_rd_addr, bus.mem_wr_addr, bus.mem_wr_data, bus.mem_wr_strb} !== '0)
      $display("FAIL rstmid_regs: got %h/%h/%h/%h want 0", bus.mem_rd_addr, bus.mem_wr_addr, bus.mem_wr_data, bus.mem_wr_strb); else n_pass++;
    @(posedge clk); #1 resetn = 1'b1;
    @(negedge clk);
    n_total++; if (bus.rd_data_valid !== '0 || bus.wr_done !== 1'b0)
      $display("FAIL rstmid_stale: got dv=%b wd=%b want 00/0", bus.rd_data_valid, bus.wr_done); else n_pass++;
    @(posedge clk); #1 idle_all();
    pack_addr(); bus.rd_req = 2'b01;
    serve_read(0, 0, 64'h55, '0, 0, 1'b1, ack_s, dv_s, ds, as_, to);
    n_total++; if (dv_s !== 2'b01 || ds !== 64'h55 || to) $display("FAIL rstmid_after: got %b/%h want 01/55", dv_s, ds); else n_pass++;
  endtask

  task automatic test_random();
    logic [NCH-1:0] pend, ack_s, dv_s, e;
    logic [DW-1:0] ds, d;
    logic [AW-1:0] as_;
    bit to;
    int g, last, k;
    do_reset();
    last = NCH - 1; pend = '0;
    for (int t = 0; t < 16; t++) begin
      for (int i = 0; i < NCH; i++)
        if (!pend[i] && $urandom_range(0, 1) == 1) begin pend[i] = 1'b1; a[i] = $urandom; end
      if (pend == '0) begin k = $urandom_range(0, NCH - 1); pend[k] = 1'b1; a[k] = $urandom; end
      pack_addr(); bus.rd_req = pend;
      g = pick(pend, last); last = g;
      e = '0; e[g] = 1'b1;
      d = {$urandom, $urandom};
      serve_read($urandom_range(0, 3), $urandom_range(0, 3), d, '0, 0, 1'b1, ack_s, dv_s, ds, as_, to);
      pend[g] = 1'b0;
      n_total++; if (to) $display("FAIL rnd_timeout t%0d: got no mem_rd_req want mem_rd_req", t); else n_pass++;
      n_total++; if (ack_s !== e) $display("FAIL rnd_ack t%0d: got %b want %b", t, ack_s, e); else n_pass++;
      n_total++; if (as_ !== a[g]) $display("FAIL rnd_addr t%0d: got %h want %h", t, as_, a[g]); else n_pass++;
      n_total++; if (dv_s !== e || ds !== d) $display("FAIL rnd_data t%0d: got %b/%h want %b/%h", t, dv_s, ds, e, d); else n_pass++;
    end
    bus.rd_req = '0;
  endtask

  initial begin
    resetn = 1'b0;
    idle_all();
    test_reset();
    test_single_read();
    test_contention();
    test_cancel();
    test_raw();
    test_concurrency();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion want completion");
    $fatal(1, "time limit");
  end
endmodule
